rr_sel_arb: RTL

RR_SEL_ARB -- requirements
Module: rr_sel_arb

---
 rtl/rr_sel_arb_pkg.sv | 20 ++
 rtl/rr_sel_arb_out_reg.sv | 40 ++++
 rtl/rr_sel_arb.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/rr_sel_arb_pkg.sv
// rr_sel_arb_pkg -- shared types and constants for the rr_sel_arb arbiter.
//   arb_state_t : arbiter state (IDLE = output empty, HOLD_A/HOLD_B = beat held from lane A/B)
//   SEL_A/SEL_B : lane encodings used for out_sel and the round-robin pointer
//   hold_state  : maps a lane select onto the matching HOLD_* state
package rr_sel_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_A = 2'd1,
    HOLD_B = 2'd2
  } arb_state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  function automatic arb_state_t hold_state(input logic sel);
    return (sel == SEL_B) ? HOLD_B : HOLD_A;
  endfunction

endpackage

// File: rtl/rr_sel_arb_out_reg.sv
// rr_sel_arb_out_reg -- output payload/select register for rr_sel_arb.
// Ports:
//   clk, rst   : clock, synchronous active-high clear (payload -> 0, select -> SEL_A)
//   ld         : load enable, captures d_data/d_sel on the rising edge
//   d_data     : payload of the granted lane
//   d_sel      : lane that supplied the payload
//   q_data     : registered payload (out_data)
//   q_sel      : registered source select (out_sel)
module rr_sel_arb_out_reg
  import rr_sel_arb_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic [DATA_W-1:0] d_data,
  input  logic              d_sel,
  output logic [DATA_W-1:0] q_data,
  output logic              q_sel
);

  logic [DATA_W-1:0] data_p1;
  logic              sel_p1;

  // ---- stage p1: output register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p1 <= '0;
      sel_p1  <= SEL_A;
    end else if (ld) begin
      data_p1 <= d_data;
      sel_p1  <= d_sel;
    end
  end

  assign q_data = data_p1;
  assign q_sel  = sel_p1;

endmodule

// File: rtl/rr_sel_arb.sv
// rr_sel_arb -- two-lane round-robin arbiter feeding one output register
// with a valid/ready handshake on every side.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   a_valid/a_data      : lane A request and payload; a_ready = beat accepted
//   b_valid/b_data      : lane B request and payload; b_ready = beat accepted
//   a_last/b_last       : end-of-packet markers (only with RR_SEL_ARB_LOCK_EN)
//   out_valid/out_data  : output register holds a beat / its payload
//   out_sel             : source lane of the held beat (0=A, 1=B)
//   out_ready           : consumer accepts the held beat
// Configuration macro:
//   RR_SEL_ARB_LOCK_EN  : when defined, a lane that sends a beat with last=0
//                         keeps the grant until it sends its last=1 beat.
module rr_sel_arb
  import rr_sel_arb_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
`ifdef RR_SEL_ARB_LOCK_EN
  input  logic              a_last,
  input  logic              b_last,
`endif
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sel,
  input  logic              out_ready
);

  arb_state_t state_q, state_d;
  logic       last_sel_q, last_sel_d;
  logic       load;
  logic       gnt_vld;
  logic       gnt_sel;
  logic       xfer;
  logic [DATA_W-1:0] gnt_data;

`ifdef RR_SEL_ARB_LOCK_EN
  logic lock_q, lock_d;
  logic lock_sel_q, lock_sel_d;
  logic beat_last;
`endif

  assign out_valid = (state_q != IDLE);

  // The only path from out_valid to the readies is through load.
  assign load = !out_valid || out_ready;

  // Grant selection: a single requester wins outright; on a tie the lane
  // that did not win last time is chosen.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_sel = SEL_A;
`ifdef RR_SEL_ARB_LOCK_EN
    if (lock_q) begin
      gnt_sel = lock_sel_q;
      gnt_vld = (lock_sel_q == SEL_B) ? b_valid : a_valid;
    end else
`endif
    if (a_valid && b_valid) begin
      gnt_vld = 1'b1;
      gnt_sel = (last_sel_q == SEL_A) ? SEL_B : SEL_A;
    end else if (a_valid) begin
      gnt_vld = 1'b1;
      gnt_sel = SEL_A;
    end else if (b_valid) begin
      gnt_vld = 1'b1;
      gnt_sel = SEL_B;
    end
  end

  // Readies are held low during reset so no beat is accepted and then dropped.
  assign xfer     = !rst && load && gnt_vld;
  assign a_ready  = xfer && (gnt_sel == SEL_A);
  assign b_ready  = xfer && (gnt_sel == SEL_B);
  assign gnt_data = (gnt_sel == SEL_B) ? b_data : a_data;

  // Next-state logic: every load cycle either captures the granted beat or
  // empties the output register.
  always_comb begin
    state_d    = state_q;
    last_sel_d = last_sel_q;
`ifdef RR_SEL_ARB_LOCK_EN
    lock_d     = lock_q;
    lock_sel_d = lock_sel_q;
    beat_last  = (gnt_sel == SEL_B) ? b_last : a_last;
`endif
    if (load) begin
      if (gnt_vld) begin
        state_d = hold_state(gnt_sel);
`ifdef RR_SEL_ARB_LOCK_EN
        lock_d     = !beat_last;
        lock_sel_d = gnt_sel;
        // The round-robin pointer moves only when a packet completes.
        if (beat_last) begin
          last_sel_d = gnt_sel;
        end
`else
        last_sel_d = gnt_sel;
`endif
      end else begin
        state_d = IDLE;
      end
    end
  end

  // ---- stage p1: arbiter control state ----
  // last_sel resets to B so that lane A wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_sel_q <= SEL_B;
`ifdef RR_SEL_ARB_LOCK_EN
      lock_q     <= 1'b0;
      lock_sel_q <= SEL_A;
`endif
    end else begin
      state_q    <= state_d;
      last_sel_q <= last_sel_d;
`ifdef RR_SEL_ARB_LOCK_EN
      lock_q     <= lock_d;
      lock_sel_q <= lock_sel_d;
`endif
    end
  end

  rr_sel_arb_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk    (clk),
    .rst    (rst),
    .ld     (xfer),
    .d_data (gnt_data),
    .d_sel  (gnt_sel),
    .q_data (out_data),
    .q_sel  (out_sel)
  );

endmodule
